// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Produces the packed four-digit BCD word consumed by the seven-segment
//   display driver, and holds the last result stable between conversions.
//
// Parameters
//   BIN_W   binary input width, legal range 4..14
//
// Ports
//   iClk    system clock, rising edge
//   iRst    asynchronous active-high reset
//   iStart  conversion request, only looked at in IDLE
//   iBin    binary value, captured on the edge that accepts iStart
//   oBcd    packed BCD result {thousands, hundreds, tens, units}, registered
//   oBusy   high from the accept edge until the result edge
//   oDone   one-cycle pulse in the cycle oBcd takes a new value
//   oOvf    last accepted iBin was above 9999 (result saturated to 9999)
//   oState  current FSM state, debug visibility only
//
// Handshake: a request is a cycle with iStart=1 while oBusy=0 (state IDLE);
// it is accepted on that rising edge. Requests while oBusy=1 are dropped,
// not queued. oDone is the only completion indication and lasts one cycle.
module bin_to_bcd_seq #(
    parameter int BIN_W = 14
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [BIN_W-1:0] iBin,
    output logic [15:0]      oBcd,
    output logic             oBusy,
    output logic             oDone,
    output logic             oOvf,
    output logic [1:0]       oState
);

    localparam int SCR_W = 16 + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned MAX_DEC = 9999;
    // Only reachable when 2^BIN_W-1 exceeds 9999; truncation for narrow
    // widths is harmless because the saturation path is then never taken.
    localparam logic [BIN_W-1:0] SAT_VAL = BIN_W'(MAX_DEC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SCR_W-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_rec_q, ovf_rec_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [31:0]      bin_ext;
    logic             bin_over;
    logic [BIN_W-1:0] bin_sat;
    logic [SCR_W-1:0] scratch_adj;
    logic [SCR_W-1:0] scratch_shl;

    // Input saturation, compared at 32 bits so every legal BIN_W works.
    always_comb begin
        bin_ext  = 32'(iBin);
        bin_over = (bin_ext > 32'(MAX_DEC));
        bin_sat  = bin_over ? SAT_VAL : iBin;
    end

    // Add-3 correction on each BCD nibble independently (no inter-nibble
    // carry), then shift the full scratch left so the binary MSB enters the
    // units LSB.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                scratch_adj[BIN_W + 4*i +: 4] = scratch_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        scratch_shl = {scratch_adj[SCR_W-2:0], 1'b0};
    end

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ovf_rec_d = ovf_rec_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    scratch_d = {16'h0000, bin_sat};
                    ovf_rec_d = bin_over;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = scratch_shl;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = scratch_q[SCR_W-1:BIN_W];
                ovf_d   = ovf_rec_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_rec_q <= 1'b0;
            bcd_q     <= 16'h0000;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovf_rec_q <= ovf_rec_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    // Busy spans exactly the SHIFT and DONE states, i.e. accept edge to
    // result edge, and drops asynchronously with reset.
    assign oBusy  = (state_q != ST_IDLE);
    assign oBcd   = bcd_q;
    assign oOvf   = ovf_q;
    assign oDone  = done_q;
    assign oState = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 14;

    logic             iClk;
    logic             iRst;
    logic             iStart;
    logic [BIN_W-1:0] iBin;
    logic [15:0]      oBcd;
    logic             oBusy;
    logic             oDone;
    logic             oOvf;
    logic [1:0]       oState;

    int total = 0;
    int bad   = 0;

    logic [16:0] exp_q[$];
    logic [16:0] last_out;
    bit          mon_en = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iStart (iStart),
        .iBin   (iBin),
        .oBcd   (oBcd),
        .oBusy  (oBusy),
        .oDone  (oDone),
        .oOvf   (oOvf),
        .oState (oState)
    );

    // ---------------- clock / reset ----------------
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got=timeout exp=finish");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: decimal digits by plain arithmetic, with saturation.
    function automatic logic [16:0] model(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {1'(v > 9999), 4'(s / 1000), 4'((s / 100) % 10),
                4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    // Every oDone pops one expected result; on all other cycles the
    // {oOvf,oBcd} pair must stay exactly where the last result left it.
    always @(negedge iClk) begin
        if (iRst) begin
            last_out = 17'h0;
        end else if (mon_en) begin
            if (oDone) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'(oDone), 32'd0);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("result_bcd", 32'(oBcd), 32'(e[15:0]));
                    check("result_ovf", 32'(oOvf), 32'(e[16]));
                end
                last_out = {oOvf, oBcd};
            end else begin
                check("hold", 32'({oOvf, oBcd}), 32'(last_out));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge iClk);
        while (oBusy && n < 100) begin
            @(negedge iClk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 32'(oBusy), 32'd0);
    endtask

    // Full conversion with latency / busy-length checks.
    task automatic convert(input int v);
        int n;
        wait_idle();
        iBin   = BIN_W'(v);
        iStart = 1'b1;
        exp_q.push_back(model(v));
        @(negedge iClk);
        iStart = 1'b0;
        // First negedge after the accept edge is n=1; oBusy should stay high
        // through n=BIN_W+1 and be low with oDone high at n=BIN_W+2.
        n = 1;
        while (oBusy && n < 100) begin
            @(negedge iClk);
            n++;
        end
        check("busy_len", 32'(n), 32'(BIN_W + 2));
        check("done_at_result", 32'(oDone), 32'd1);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(negedge iClk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int v;
        int dir_vals[5];
        iRst   = 1'b0;
        iStart = 1'b0;
        iBin   = '0;
        #3 iRst = 1'b1;
        #1;
        check("rst_bcd",  32'(oBcd),  32'h0000);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_ovf",  32'(oOvf),  32'd0);
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        last_out = 17'h0;
        mon_en = 1;
        idle_cycles(2);

        // Nominal and boundary values.
        dir_vals[0] = 1234;
        dir_vals[1] = 0;
        dir_vals[2] = 9999;
        dir_vals[3] = 10000;
        dir_vals[4] = 16383;
        foreach (dir_vals[i]) convert(dir_vals[i]);

        // Start while busy: the second request must be dropped.
        wait_idle();
        iBin = BIN_W'(42);
        iStart = 1'b1;
        exp_q.push_back(model(42));
        @(negedge iClk);
        iStart = 1'b0;
        idle_cycles(4);
        iBin = BIN_W'(7777);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        idle_cycles(30);
        check("busy_ignored_idle", 32'(oBusy), 32'd0);
        check("busy_ignored_q", 32'(exp_q.size()), 32'd0);
        convert(7777);

        // Back-to-back with iStart held high.
        wait_idle();
        iBin = BIN_W'(58);
        iStart = 1'b1;
        exp_q.push_back(model(58));
        @(negedge iClk);
        iBin = BIN_W'(905);
        exp_q.push_back(model(905));
        n = 1;
        while (oBusy && n < 100) begin
            @(negedge iClk);
            n++;
        end
        check("b2b_first_len", 32'(n), 32'(BIN_W + 2));
        @(negedge iClk);
        check("b2b_reaccept", 32'(oBusy), 32'd1);
        iStart = 1'b0;
        wait_idle();
        idle_cycles(2);

        // Randomized values, biased toward the in-range region.
        for (int i = 0; i < 24; i++) begin
            if (i % 4 == 0) v = int'($urandom_range(16383, 10000));
            else            v = int'($urandom_range(9999, 0));
            convert(v);
        end

        // Reset mid-conversion.
        convert(321);
        wait_idle();
        iBin = BIN_W'(8888);
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        idle_cycles(6);
        #2 iRst = 1'b1;
        #1;
        check("midrst_bcd",  32'(oBcd),  32'h0000);
        check("midrst_busy", 32'(oBusy), 32'd0);
        check("midrst_done", 32'(oDone), 32'd0);
        check("midrst_ovf",  32'(oOvf),  32'd0);
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        idle_cycles(25);
        check("midrst_no_result", 32'(oBcd), 32'h0000);
        convert(8888);

        idle_cycles(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
